// File: rtl/fp_pkg.sv
// Shared definitions for the sequential binary32 divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ITER  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;

    // Positions inside out_flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLG_NV = 3;
    localparam int FLG_DZ = 2;
    localparam int FLG_OF = 1;
    localparam int FLG_UF = 0;

    // Number of quotient bits produced: 24 mantissa bits plus one guard bit
    localparam logic [4:0] ITER_STEPS = 5'd25;

endpackage

// File: rtl/fp_classify.sv
// Splits a binary32 word into fields and flags its class; denormals read as zero.
// Latency: combinational.
// Backpressure: none, pure function of the input word.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] word,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    localparam logic [7:0] EXP_ALL_ONES = 8'(EXP_MAX);

    logic       exp_zero;
    logic       exp_ones;
    logic       frac_zero;

    // Field extraction and class decode
    always_comb begin
        sign      = word[31];
        exp       = word[30:23];
        exp_zero  = (word[30:23] == 8'd0);
        exp_ones  = (word[30:23] == EXP_ALL_ONES);
        frac_zero = (word[22:0] == 23'd0);
        // Flush-to-zero: any zero exponent (true zero or denormal) counts as zero
        is_zero   = exp_zero;
        is_inf    = exp_ones && frac_zero;
        is_nan    = exp_ones && !frac_zero;
        mant      = exp_zero ? 24'd0 : {1'b1, word[22:0]};
    end

endmodule

// File: rtl/fp_seq_divider.sv
// Iterative binary32 divider a/b: restoring division, one quotient bit per cycle, RNE rounding.
// Latency: 27 cycles for ordinary operands, 1 cycle after acceptance for special operands.
// Backpressure: result held in DONE until out_ready; no new operands accepted until then.
module fp_seq_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  out_flags
);

    div_state_t         state;

    logic [31:0]        a_q;
    logic [31:0]        b_q;

    logic               sa, sb;
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic               a_zero, a_inf, a_nan;
    logic               b_zero, b_inf, b_nan;

    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [25:0]        r_q;
    // Low 24 bits of the 25-bit quotient; the leading bit always ends at 1
    // after normalisation, so it is never stored.
    logic [23:0]        q_q;
    logic [4:0]         cnt_q;

    fp_classify u_cls_a (
        .word    (a_q),
        .sign    (sa),
        .exp     (ea),
        .mant    (ma),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    fp_classify u_cls_b (
        .word    (b_q),
        .sign    (sb),
        .exp     (eb),
        .mant    (mb),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    assign in_ready = (state == IDLE) && !rst;

    // Special-operand decode, in priority order
    logic               spec_vld;
    logic [31:0]        spec_res;
    logic [3:0]         spec_flg;
    logic               sign_n;

    always_comb begin
        spec_vld = 1'b0;
        spec_res = 32'd0;
        spec_flg = 4'd0;
        sign_n   = sa ^ sb;
        if (a_nan || b_nan) begin
            spec_vld = 1'b1;
            spec_res = QNAN;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_vld         = 1'b1;
            spec_res         = QNAN;
            spec_flg[FLG_NV] = 1'b1;
        end else if (a_inf) begin
            spec_vld = 1'b1;
            spec_res = {sign_n, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            spec_vld = 1'b1;
            spec_res = {sign_n, 31'd0};
        end else if (b_zero) begin
            spec_vld         = 1'b1;
            spec_res         = {sign_n, 8'hFF, 23'd0};
            spec_flg[FLG_DZ] = 1'b1;
        end
    end

    // Normal-path setup: biased exponent and pre-normalised partial remainder
    logic signed [9:0]  e_raw;
    logic signed [9:0]  e_init;
    logic [25:0]        r_init;
    logic               ma_lt_mb;

    always_comb begin
        e_raw    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BIAS);
        ma_lt_mb = (ma < mb);
        // Doubling a smaller dividend keeps the leading quotient bit at 1
        r_init   = ma_lt_mb ? {1'b0, ma, 1'b0} : {2'b00, ma};
        e_init   = ma_lt_mb ? (e_raw - 10'sd1) : e_raw;
    end

    // One restoring-division step
    logic [25:0]        mb_ext;
    logic               ge;
    logic [25:0]        r_diff;
    logic [25:0]        r_next;

    always_comb begin
        mb_ext = {2'b00, mb};
        ge     = (r_q >= mb_ext);
        r_diff = ge ? (r_q - mb_ext) : r_q;
        r_next = r_diff << 1;
    end

    // Round-to-nearest-even and range check on the finished quotient
    logic               round_up;
    logic [23:0]        frac_sum;
    logic signed [9:0]  rnd_exp;
    logic [31:0]        rnd_res;
    logic [3:0]         rnd_flg;

    always_comb begin
        round_up = q_q[0] && ((r_q != 26'd0) || q_q[1]);
        // Bit 23 of the sum is the carry out of the 24-bit mantissa
        frac_sum = {1'b0, q_q[23:1]} + {23'd0, round_up};
        rnd_exp  = exp_q + $signed({9'd0, frac_sum[23]});
        rnd_flg  = 4'd0;
        if (rnd_exp >= 10'(EXP_MAX)) begin
            rnd_res          = {sign_q, 8'hFF, 23'd0};
            rnd_flg[FLG_OF]  = 1'b1;
        end else if (rnd_exp <= 10'sd0) begin
            rnd_res          = {sign_q, 31'd0};
            rnd_flg[FLG_UF]  = 1'b1;
        end else begin
            // On carry the fraction field is already all zeros
            rnd_res          = {sign_q, rnd_exp[7:0], frac_sum[22:0]};
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= 32'd0;
            out_flags <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (spec_vld) begin
                        out       <= spec_res;
                        out_flags <= spec_flg;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state     <= ITER;
                    end
                end
                ITER: begin
                    if (cnt_q == 5'd1) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    out       <= rnd_res;
                    out_flags <= rnd_flg;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand capture and divide datapath (no reset needed, qualified by state)
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
        if (state == SETUP) begin
            sign_q <= sign_n;
            exp_q  <= e_init;
            r_q    <= r_init;
            q_q    <= 24'd0;
            cnt_q  <= ITER_STEPS;
        end else if (state == ITER) begin
            r_q    <= r_next;
            q_q    <= {q_q[22:0], ge};
            cnt_q  <= cnt_q - 5'd1;
        end
    end

endmodule

// File: tb/tb_fp_seq_divider.sv
// Self-checking bench for fp_seq_divider: directed corner cases plus random operands.
// Latency: checks edge count from acceptance to out_valid.
// Backpressure: exercises held out_ready=0 and mid-operation reset.
module tb_fp_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_errors = 0;

    fp_seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact rational quotient of the mantissas, rounded to nearest even.
    // lat is the number of clock edges from acceptance until out_valid is seen.
    task automatic ref_div(input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] res, output logic [3:0] flg, output int lat);
        logic s;
        logic a_z, a_i, a_n, b_z, b_i, b_n;
        longint unsigned ma, mb, num, qt, rem;
        int e, sh;
        s   = av[31] ^ bv[31];
        a_z = (av[30:23] == 8'd0);
        b_z = (bv[30:23] == 8'd0);
        a_i = (av[30:23] == 8'hFF) && (av[22:0] == 23'd0);
        b_i = (bv[30:23] == 8'hFF) && (bv[22:0] == 23'd0);
        a_n = (av[30:23] == 8'hFF) && (av[22:0] != 23'd0);
        b_n = (bv[30:23] == 8'hFF) && (bv[22:0] != 23'd0);
        flg = 4'd0;
        lat = 1;
        if (a_n || b_n) begin
            res = 32'h7FC00000;
        end else if ((a_i && b_i) || (a_z && b_z)) begin
            res = 32'h7FC00000; flg = 4'b1000;
        end else if (a_i) begin
            res = {s, 8'hFF, 23'd0};
        end else if (b_i || a_z) begin
            res = {s, 31'd0};
        end else if (b_z) begin
            res = {s, 8'hFF, 23'd0}; flg = 4'b0100;
        end else begin
            lat = 27;
            ma  = 64'({1'b1, av[22:0]});
            mb  = 64'({1'b1, bv[22:0]});
            e   = int'(av[30:23]) - int'(bv[30:23]) + 127;
            sh  = (ma >= mb) ? 23 : 24;
            if (sh == 24) e = e - 1;
            num = ma << sh;
            qt  = num / mb;
            rem = num % mb;
            if ((2 * rem > mb) || ((2 * rem == mb) && qt[0])) qt = qt + 1;
            if (qt == (64'd1 << 24)) begin
                qt = 64'd1 << 23;
                e  = e + 1;
            end
            if (e >= 255) begin
                res = {s, 8'hFF, 23'd0}; flg = 4'b0010;
            end else if (e <= 0) begin
                res = {s, 31'd0}; flg = 4'b0001;
            end else begin
                res = {s, 8'(e), qt[22:0]};
            end
        end
    endtask

    // One full transaction; hold = cycles of out_ready=0 after out_valid rises
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [31:0] exp_res;
        logic [3:0]  exp_flg;
        int          exp_lat;
        int          waits;
        int          edges;
        int          bad;
        ref_div(av, bv, exp_res, exp_flg, exp_lat);
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        check_val({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
        a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!out_valid && edges < 60);
        check_val({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check_val({tag, " out"}, 64'(out), 64'(exp_res));
        check_val({tag, " flags"}, 64'(out_flags), 64'(exp_flg));
        if (hold > 0) begin
            bad = 0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (out !== exp_res || out_flags !== exp_flg || out_valid !== 1'b1 || in_ready !== 1'b0)
                    bad++;
            end
            check_val({tag, " hold_unstable_cycles"}, 64'(bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, " out_valid_after_hs"}, 64'(out_valid), 64'd0);
        check_val({tag, " in_ready_after_hs"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        logic [31:0] specials [8];
        specials[0] = 32'h00000000; specials[1] = 32'h80000000;
        specials[2] = 32'h7F800000; specials[3] = 32'hFF800000;
        specials[4] = 32'h7FC00000; specials[5] = 32'h00000123;
        specials[6] = 32'h3F800000; specials[7] = 32'h7F7FFFFF;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset out_valid", 64'(out_valid), 64'd0);
        check_val("reset out", 64'(out), 64'd0);
        check_val("reset flags", 64'(out_flags), 64'd0);
        check_val("reset in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("reset in_ready_release", 64'(in_ready), 64'd1);

        run_op("3/2_bp", 32'h40400000, 32'h40000000, 10);
        run_op("1/3", 32'h3F800000, 32'h40400000, 0);
        run_op("1/1", 32'h3F800000, 32'h3F800000, 0);
        run_op("1/0", 32'h3F800000, 32'h00000000, 0);
        run_op("0/-0", 32'h00000000, 32'h80000000, 0);
        run_op("nan/1", 32'h7FC00001, 32'h3F800000, 0);
        run_op("ovf", 32'h7F7FFFFF, 32'h00800000, 0);
        run_op("ufl", 32'h00800000, 32'h40000000, 0);
        run_op("ufl_neg", 32'h80800000, 32'h40000000, 0);
        run_op("inf/inf", 32'h7F800000, 32'hFF800000, 2);
        run_op("-inf/2", 32'hFF800000, 32'h40000000, 0);
        run_op("2/inf", 32'h40000000, 32'h7F800000, 0);

        // Reset during the 10th ITER cycle (acceptance E0, ITER spans E2..E26)
        a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst out_valid_in_rst", 64'(out_valid), 64'd0);
        check_val("midrst in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("midrst in_ready_release", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_val("midrst stray_out_valid", 64'(seen), 64'd0);
        run_op("10/5", 32'h41200000, 32'h40A00000, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) ra = specials[$urandom_range(0, 7)];
            else ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) rb = specials[$urandom_range(0, 7)];
            else rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op("rand", ra, rb, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
